// File: rtl/operand_loader_if.sv
// Pin-side bus of operand_loader: raw 12-bit host pins in, operands/opcode and
// handshake/debug flags out to the FPU and result buffer.
interface operand_loader_if;
  logic [11:0] io_in;
  logic [9:0]  num1;
  logic [9:0]  num2;
  logic [3:0]  op;
  logic        start;
  logic        ready;
  logic [1:0]  phase;
  logic        timeout;

  modport master (
    output io_in,
    input  num1, num2, op, start, ready, phase, timeout
  );

  modport slave (
    input  io_in,
    output num1, num2, op, start, ready, phase, timeout
  );
endinterface

// File: rtl/operand_loader.sv
// FPU operand loader: synchronises io_in, captures A, B and opcode on strobe rises, pulses start.
// Optional stall abort is compiled in with `define OPERAND_TIMEOUT_EN.
module operand_loader #(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic            clock,
  input  logic            reset,
  operand_loader_if.slave bus
);

  typedef enum logic [1:0] {
    S_A   = 2'b00,
    S_B   = 2'b01,
    S_OP  = 2'b10,
    S_BAD = 2'b11
  } state_t;

  if (SYNC_STAGES < 2 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("operand_loader: SYNC_STAGES and TIMEOUT_CYCLES must both be at least 2");
  end

  logic [11:0] sync_q [SYNC_STAGES];
  logic [11:0] s_in;
  logic        s_stb;
  logic        s_clr;
  logic [9:0]  s_payload;
  logic        stb_q;
  logic        rise;

  state_t      state_q;
  state_t      state_d;
  logic        ld_a;
  logic        ld_b;
  logic        ld_op;
  logic        expire;

  logic [9:0]  num1_q;
  logic [9:0]  num2_q;
  logic [3:0]  op_q;
  logic        start_q;

  // Whole bus goes through the same chain so payload stays aligned with strobe/clear.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      stb_q <= 1'b0;
    end else begin
      sync_q[0] <= bus.io_in;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      stb_q <= s_stb;
    end
  end

  assign s_in      = sync_q[SYNC_STAGES-1];
  assign s_stb     = s_in[11];
  assign s_clr     = s_in[10];
  assign s_payload = s_in[9:0];
  assign rise      = s_stb & ~stb_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_A;
    end else begin
      state_q <= state_d;
    end
  end

  // Clear beats a simultaneous rise (that edge is still consumed via stb_q); both beat expiry.
  always_comb begin
    state_d = state_q;
    ld_a    = 1'b0;
    ld_b    = 1'b0;
    ld_op   = 1'b0;
    if (s_clr) begin
      state_d = S_A;
    end else if (rise) begin
      case (state_q)
        S_A: begin
          ld_a    = 1'b1;
          state_d = S_B;
        end
        S_B: begin
          ld_b    = 1'b1;
          state_d = S_OP;
        end
        S_OP: begin
          ld_op   = 1'b1;
          state_d = S_A;
        end
        default: state_d = S_A;
      endcase
    end else if (expire || state_q == S_BAD) begin
      state_d = S_A;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      num1_q  <= '0;
      num2_q  <= '0;
      op_q    <= '0;
      start_q <= 1'b0;
    end else begin
      start_q <= ld_op;
      if (ld_a) begin
        num1_q <= s_payload;
      end
      if (ld_b) begin
        num2_q <= s_payload;
      end
      if (ld_op) begin
        op_q <= s_payload[3:0];
      end
    end
  end

`ifdef OPERAND_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q;
  logic          timeout_q;

  assign expire = (state_q == S_B || state_q == S_OP) &&
                  (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (rise || s_clr || state_q == S_A) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (rise || s_clr) begin
        timeout_q <= 1'b0;
      end else if (expire) begin
        timeout_q <= 1'b1;
      end
    end
  end

  assign bus.timeout = timeout_q;
`else
  assign expire      = 1'b0;
  assign bus.timeout = 1'b0;
`endif

  assign bus.num1  = num1_q;
  assign bus.num2  = num2_q;
  assign bus.op    = op_q;
  assign bus.start = start_q;
  assign bus.ready = (state_q == S_A);
  assign bus.phase = state_q;

endmodule

// File: tb/tb_operand_loader.sv
// Directed bench for operand_loader: every-cycle comparison against a transaction-level
// model (delay line + slot counter), plus hand-computed literal checks.
module tb_operand_loader;

  localparam int SYNC = 2;
  localparam int TMO  = 8;
`ifdef OPERAND_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  operand_loader_if bus ();

  operand_loader #(
    .SYNC_STAGES   (SYNC),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  int vectors     = 0;
  int miscompares = 0;
  int starts      = 0;
  bit chk_en      = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: raw samples take SYNC edges to be seen; each seen rise fills the next slot.
  logic [11:0] pipe [$];
  int          slot;
  int          waited;
  logic        prev;
  logic [9:0]  m_num1;
  logic [9:0]  m_num2;
  logic [3:0]  m_op;
  logic        m_start;
  logic        m_to;

  always @(posedge clock or posedge reset) begin : model
    logic [11:0] s;
    logic        seen;
    if (reset) begin
      pipe.delete();
      for (int i = 0; i < SYNC; i++) pipe.push_back(12'h000);
      prev = 1'b0; slot = 0; waited = 0;
      m_num1 = '0; m_num2 = '0; m_op = '0; m_start = 1'b0; m_to = 1'b0;
    end else begin
      s = pipe.pop_front();
      pipe.push_back(bus.io_in);
      seen    = s[11] && !prev;
      prev    = s[11];
      m_start = 1'b0;
      if (s[10]) begin
        slot = 0; waited = 0; m_to = 1'b0;
      end else if (seen) begin
        if (slot == 0) m_num1 = s[9:0];
        else if (slot == 1) m_num2 = s[9:0];
        else begin
          m_op    = s[3:0];
          m_start = 1'b1;
        end
        slot = (slot + 1) % 3; waited = 0; m_to = 1'b0;
      end else if (TO_EN && slot != 0) begin
        waited++;
        if (waited == TMO) begin
          slot = 0; waited = 0; m_to = 1'b1;
        end
      end
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      chk("num1",    32'(bus.num1),    32'(m_num1));
      chk("num2",    32'(bus.num2),    32'(m_num2));
      chk("op",      32'(bus.op),      32'(m_op));
      chk("start",   32'(bus.start),   32'(m_start));
      chk("ready",   32'(bus.ready),   32'(slot == 0));
      chk("phase",   32'(bus.phase),   32'(slot));
      chk("timeout", 32'(bus.timeout), 32'(m_to));
    end
    if (bus.start === 1'b1) starts++;
  end

  task automatic strobe(input logic [9:0] p, input int hi, input int lo);
    bus.io_in = {2'b10, p};
    repeat (hi) @(negedge clock);
    bus.io_in = {2'b00, p};
    repeat (lo) @(negedge clock);
  endtask

  initial begin
    int s0;
    bus.io_in = '0;
    reset     = 1'b1;
    repeat (2) @(negedge clock);
    reset  = 1'b0;
    chk_en = 1'b1;
    chk("rst_num1",  32'(bus.num1),    32'h0);
    chk("rst_num2",  32'(bus.num2),    32'h0);
    chk("rst_op",    32'(bus.op),      32'h0);
    chk("rst_start", 32'(bus.start),   32'h0);
    chk("rst_ready", 32'(bus.ready),   32'h1);
    chk("rst_phase", 32'(bus.phase),   32'h0);
    chk("rst_to",    32'(bus.timeout), 32'h0);

    // Basic sequence; start must appear exactly 3 edges after the raw opcode rise.
    strobe(10'h155, 4, 4);
    chk("ready_after_a", 32'(bus.ready), 32'h0);
    strobe(10'h0AA, 4, 4);
    s0 = starts;
    bus.io_in = {2'b10, 10'h003};
    @(negedge clock); chk("start_e1", 32'(bus.start), 32'h0);
    @(negedge clock); chk("start_e2", 32'(bus.start), 32'h0);
    chk("ready_pre_op", 32'(bus.ready), 32'h0);
    @(negedge clock); chk("start_e3", 32'(bus.start), 32'h1);
    @(negedge clock); chk("start_e4", 32'(bus.start), 32'h0);
    bus.io_in = {2'b00, 10'h003};
    repeat (4) @(negedge clock);
    chk("seq1_num1",   32'(bus.num1),  32'h155);
    chk("seq1_num2",   32'(bus.num2),  32'h0AA);
    chk("seq1_op",     32'(bus.op),    32'h3);
    chk("seq1_starts", 32'(starts - s0), 32'd1);

    // Held strobe captures once.
    bus.io_in = {2'b10, 10'h3FF};
    repeat (10) @(negedge clock);
    chk("hold_num1_10",  32'(bus.num1),  32'h3FF);
    chk("hold_phase_10", 32'(bus.phase), 32'h1);
    repeat (10) @(negedge clock);
    chk("hold_num1_20",  32'(bus.num1),  32'h3FF);
    chk("hold_num2_20",  32'(bus.num2),  32'h0AA);
    chk("hold_phase_20", 32'(bus.phase), TO_EN ? 32'h0 : 32'h1);
    bus.io_in = '0;
    repeat (4) @(negedge clock);

    // Clear back to S_A, load A, then clear together with a strobe.
    bus.io_in = {2'b01, 10'h000};
    repeat (2) @(negedge clock);
    bus.io_in = '0;
    repeat (4) @(negedge clock);
    chk("clr_phase", 32'(bus.phase), 32'h0);
    strobe(10'h010, 4, 4);
    chk("a010_phase", 32'(bus.phase), 32'h1);
    s0 = starts;
    bus.io_in = {2'b11, 10'h2AA};
    repeat (4) @(negedge clock);
    bus.io_in = '0;
    repeat (6) @(negedge clock);
    chk("clrstb_phase", 32'(bus.phase), 32'h0);
    chk("clrstb_num1",  32'(bus.num1),  32'h010);
    chk("clrstb_num2",  32'(bus.num2),  32'h0AA);
    chk("clrstb_start", 32'(starts - s0), 32'd0);

    // Two sequences back to back, minimal strobe spacing.
    s0 = starts;
    strobe(10'h001, 1, 1);
    strobe(10'h002, 1, 1);
    strobe(10'h00C, 1, 1);
    strobe(10'h123, 1, 1);
    strobe(10'h234, 1, 1);
    strobe(10'h3F5, 1, 1);
    repeat (6) @(negedge clock);
    chk("b2b_starts", 32'(starts - s0), 32'd2);
    chk("b2b_num1",   32'(bus.num1),  32'h123);
    chk("b2b_num2",   32'(bus.num2),  32'h234);
    chk("b2b_op",     32'(bus.op),    32'h5);

    // Reset while waiting for the opcode.
    strobe(10'h0F0, 2, 2);
    strobe(10'h00F, 2, 2);
    chk("sop_phase", 32'(bus.phase), 32'h2);
    s0 = starts;
    bus.io_in = {2'b10, 10'h009};
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    chk("arst_num1",  32'(bus.num1),    32'h0);
    chk("arst_num2",  32'(bus.num2),    32'h0);
    chk("arst_op",    32'(bus.op),      32'h0);
    chk("arst_start", 32'(bus.start),   32'h0);
    chk("arst_ready", 32'(bus.ready),   32'h1);
    chk("arst_phase", 32'(bus.phase),   32'h0);
    chk("arst_to",    32'(bus.timeout), 32'h0);
    repeat (3) @(negedge clock);
    bus.io_in = '0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (6) @(negedge clock);
    chk("arst_nostart", 32'(starts - s0), 32'd0);
    chk("arst_op_after", 32'(bus.op), 32'h0);

`ifdef OPERAND_TIMEOUT_EN
    // Capture lands 3 edges after the raw rise; abort 8 edges after that.
    bus.io_in = {2'b10, 10'h055};
    repeat (10) @(negedge clock);
    chk("to_phase_pre", 32'(bus.phase),   32'h1);
    chk("to_flag_pre",  32'(bus.timeout), 32'h0);
    @(negedge clock);
    chk("to_phase",  32'(bus.phase),   32'h0);
    chk("to_flag",   32'(bus.timeout), 32'h1);
    chk("to_num1",   32'(bus.num1),    32'h055);
    bus.io_in = '0;
    repeat (3) @(negedge clock);
    chk("to_sticky", 32'(bus.timeout), 32'h1);
    strobe(10'h066, 4, 4);
    chk("to_cleared", 32'(bus.timeout), 32'h0);
    chk("to_reload",  32'(bus.num1),    32'h066);
    chk("to_phase2",  32'(bus.phase),   32'h1);
`else
    // Without the abort the loader waits indefinitely in S_B.
    bus.io_in = {2'b10, 10'h055};
    repeat (40) @(negedge clock);
    chk("wait_phase", 32'(bus.phase),   32'h1);
    chk("wait_to",    32'(bus.timeout), 32'h0);
    chk("wait_num1",  32'(bus.num1),    32'h055);
    bus.io_in = '0;
    repeat (4) @(negedge clock);
`endif

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
